dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequences LOAD/STORE accesses from the MEM stage onto a multi-cycle, req/ack data memory.
//  Generates byte enables and lane-shifted write data, then extracts and extends load data.
//  Stalls the pipeline until the access completes. Retires a hung access via a timeout counter.
//  Sits between the MEM-stage control signals (MemRead/MemWrite, funct3, ALU address) and the data memory.
// PARAMETERS
//  TIMEOUT   16  max cycles in ACCESS without mem_ack before abort (>=2)
//  CNT_W      5  timeout counter width; must hold TIMEOUT
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high reset
//  MemRead    in   1   MEM-stage load request
//  MemWrite   in   1   MEM-stage store request
//  Funct3     in   3   size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  Addr       in   32  byte address from ALU
//  WrData     in   32  store data (rs2)
//  RdData     out  32  extended load result; valid in RESP cycle
//  Stall      out  1   hold IF..MEM pipeline registers (combinational)
//  Error      out  1   one-cycle pulse in RESP: access timed out
//  Misalign   out  1   one-cycle pulse in RESP: misaligned access (MISALIGN_CHECK_EN only)
//  mem_req    out  1   memory request, held until mem_ack
//  mem_we     out  1   1 = write
//  mem_addr   out  32  word address {Addr[31:2],2'b00}
//  mem_be     out  4   byte enables
//  mem_wdata  out  32  lane-aligned write data
//  mem_ack    in   1   memory completion (one cycle)
//  mem_rdata  in   32  read word, valid with mem_ack
// BEHAVIOUR
//  Reset: state=IDLE, counter=0; mem_req/mem_we/mem_be/mem_addr/mem_wdata/RdData/Error/Misalign = 0.
//  Reset applies mid-access: the request is abandoned; mem_req is 0 after the edge; a late mem_ack is ignored.
//  Stall = (IDLE & (MemRead|MemWrite)) | ACCESS. Stall is 0 in RESP, so the pipeline advances at the end of RESP.
//  IDLE: on MemRead|MemWrite, register mem_addr, mem_be, mem_wdata and mem_we (=MemWrite) plus Funct3/Addr[1:0] -> ACCESS.
//   MemRead&MemWrite together is handled as a write.
//  ACCESS: mem_req=1; all mem_* outputs stable. The counter increments each cycle.
//   mem_ack -> capture+extend mem_rdata into RdData (loads only) -> RESP.
//   No ack and counter==TIMEOUT-1 -> RESP, Error=1, RdData=0. If ack coincides with the limit, ack wins.
//  RESP: one cycle; mem_req=0; inputs ignored; counter cleared -> IDLE. A back-to-back access is issued from the IDLE that follows.
//  mem_ack outside ACCESS: ignored.
//  Latency: a load with ack after N cycles in ACCESS stalls N+1 cycles; RdData is valid in the RESP cycle.
//  Lanes (o=Addr[1:0]):
//   B: be=4'b0001<<o, wdata={4{WrData[7:0]}}.
//   H: be=4'b0011<<{o[1],0}, wdata={2{WrData[15:0]}}.
//   W/other: be=4'b1111, wdata=WrData.
//  Load extraction: byte at lane o, half at lane o[1]. B/H sign-extend; BU/HU zero-extend; W passes through.
//   Undefined funct3 is treated as W.
//  RdData holds its value until the next completed load. Stores leave RdData unchanged.
// CONFIGURATION
//  MISALIGN_CHECK_EN defined:
//   H with o[0]=1, or W with o!=0, issues no memory request.
//   IDLE -> RESP directly, Misalign=1, RdData=0. Stall=1 for exactly one cycle.
//  Undefined: the Misalign output is tied 0. Low address bits below the access size are ignored (H uses o[1]; W uses none).
// TESTING
//  LW Addr=0x100, ack after 3 cycles, rdata=0xDEADBEEF -> mem_be=1111, Stall high 4 cycles, RdData=0xDEADBEEF.
//  LB Addr=0x103, rdata=0x80FF_0000 -> mem_be=1000, RdData=0xFFFFFF80.
//   LBU same stimulus -> RdData=0x00000080.
//  SH Addr=0x202, WrData=0x1234ABCD -> mem_we=1, mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD.
//  Load with no ack, TIMEOUT=16 -> mem_req high 16 cycles, then Error pulse, RdData=0, Stall drops.
//  Reset asserted in cycle 2 of ACCESS, then ack -> mem_req=0 next cycle, ack ignored, state IDLE.
//  MISALIGN_CHECK_EN: LW Addr=0x101 -> no mem_req, Misalign pulse, Stall=1 for one cycle.
//   Macro undefined: same stimulus -> mem_be=1111, mem_addr=0x100.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_access_ctrl                                             |
// | Description : Sequences MEM-stage loads/stores onto a multi-cycle req/ack  |
// |               data memory. Builds byte enables and lane-replicated write   |
// |               data, extracts and extends load data, stalls the pipeline    |
// |               while an access is outstanding and retires a hung access     |
// |               through a timeout counter.                                   |
// |               Optional feature macro: MISALIGN_CHECK_EN (misaligned H/W    |
// |               accesses are rejected without a memory request).             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dmem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        Stall,
    output logic        Error,
    output logic        Misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_f3;
    logic [1:0]        r_off;
    logic [31:0]       r_rddata;
    logic              r_error;
    logic              r_misalign;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [31:0]       r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;

    logic              w_req;
    logic [1:0]        w_off;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_misalign;
    logic [31:0]       w_shift;
    logic [31:0]       w_load;

    assign w_req = MemRead | MemWrite;
    assign w_off = Addr[1:0];

    // Byte enables and lane-replicated write data for the incoming access
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WrData;
        case (Funct3)
            3'b000, 3'b100: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{WrData[7:0]}};
            end
            3'b001, 3'b101: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{WrData[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = WrData;
            end
        endcase
    end

`ifdef MISALIGN_CHECK_EN
    // Halfword needs an even offset, word (and anything treated as word) offset 0
    always_comb begin
        w_misalign = 1'b0;
        case (Funct3)
            3'b000, 3'b100: w_misalign = 1'b0;
            3'b001, 3'b101: w_misalign = w_off[0];
            default:        w_misalign = (w_off != 2'b00);
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    // Select the addressed lane of the returned word and extend it
    assign w_shift = mem_rdata >> {r_off, 3'b000};
    always_comb begin
        w_load = mem_rdata;
        case (r_f3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b001:  w_load = r_off[1] ? {{16{mem_rdata[31]}}, mem_rdata[31:16]}
                                       : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            3'b101:  w_load = r_off[1] ? {16'd0, mem_rdata[31:16]}
                                       : {16'd0, mem_rdata[15:0]};
            default: w_load = mem_rdata;
        endcase
    end

    // Access sequencer: IDLE -> ACCESS -> RESP -> IDLE with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_f3        <= 3'd0;
            r_off       <= 2'd0;
            r_rddata    <= 32'd0;
            r_error     <= 1'b0;
            r_misalign  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_be    <= 4'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_misalign) begin
                            r_misalign <= 1'b1;
                            r_rddata   <= 32'd0;
                            r_state    <= RESP;
                        end else begin
                            r_mem_addr  <= {Addr[31:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                            r_mem_we    <= MemWrite;
                            r_f3        <= Funct3;
                            r_off       <= w_off;
                            r_mem_req   <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // A completing ack takes priority over the timeout limit
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_rddata <= w_load;
                        end
                        r_state <= RESP;
                    end else if (r_cnt == c_cnt_last) begin
                        r_mem_req <= 1'b0;
                        r_error   <= 1'b1;
                        r_rddata  <= 32'd0;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    r_error    <= 1'b0;
                    r_misalign <= 1'b0;
                    r_cnt      <= '0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Stall     = ((r_state == IDLE) && w_req) || (r_state == ACCESS);
    assign RdData    = r_rddata;
    assign Error     = r_error;
    assign Misalign  = r_misalign;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dmem_access_ctrl                                          |
// | Description : Scoreboard bench for dmem_access_ctrl: directed accesses     |
// |               push expected requests/responses, a monitor pops and checks. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  Funct3 = 3'd0;
    logic [31:0] Addr = 32'd0;
    logic [31:0] WrData = 32'd0;
    logic [31:0] RdData;
    logic        Stall;
    logic        Error;
    logic        Misalign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .Addr(Addr), .WrData(WrData), .RdData(RdData),
        .Stall(Stall), .Error(Error), .Misalign(Misalign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        mis;
        int          stall;
        int          reqc;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cur_ackdly = 0;
    logic [31:0] cur_rdata = 32'd0;
    logic        force_ack = 1'b0;
    bit          mon_en = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: acks in the cur_ackdly-th request cycle (0 = never)
    int k_ack = 0;
    always @(negedge clk) begin
        if (mem_req) begin
            k_ack     = k_ack + 1;
            mem_ack   = (k_ack == cur_ackdly);
            mem_rdata = cur_rdata;
        end else begin
            k_ack     = 0;
            mem_ack   = force_ack;
            mem_rdata = cur_rdata;
        end
    end

    // Monitor: request fields at mem_req rise, response at Stall fall
    bit prev_stall = 1'b0;
    bit prev_req = 1'b0;
    int st_cnt = 0;
    int rq_cnt = 0;
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_stall = 1'b0;
            prev_req   = 1'b0;
            st_cnt     = 0;
            rq_cnt     = 0;
        end else begin
            if (mem_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_req: actual addr=%h required no request", mem_addr);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    check32("mem_we",    32'(mem_we),   32'(r.we));
                    check32("mem_addr",  mem_addr,      r.addr);
                    check32("mem_be",    32'(mem_be),   32'(r.be));
                    check32("mem_wdata", mem_wdata,     r.wdata);
                end
            end
            if (prev_stall && !Stall) begin
                if (rsp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_rsp: actual RdData=%h required no response", RdData);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    check32("RdData",     RdData,          e.rd);
                    check32("Error",      32'(Error),      32'(e.err));
                    check32("Misalign",   32'(Misalign),   32'(e.mis));
                    check32("stall_len",  32'(st_cnt),     32'(e.stall));
                    check32("req_len",    32'(rq_cnt),     32'(e.reqc));
                end
                st_cnt = 0;
                rq_cnt = 0;
            end else begin
                check32("idle_flags", {30'd0, Error, Misalign}, 32'd0);
            end
            if (Stall)   st_cnt++;
            if (mem_req) rq_cnt++;
            prev_stall = Stall;
            prev_req   = mem_req;
        end
    end

    // Issue one access (called just after a posedge, in IDLE) and wait for its RESP
    task automatic run_vec(
        input logic rd, input logic wr, input logic [2:0] f3,
        input logic [31:0] addr, input logic [31:0] wd,
        input int ackd, input logic [31:0] rdat,
        input bit has_req, input logic ewe, input logic [31:0] eaddr,
        input logic [3:0] ebe, input logic [31:0] ewd,
        input logic [31:0] erd, input logic eerr, input logic emis,
        input int est, input int erq);
        req_t r;
        rsp_t e;
        int   n;
        if (has_req) begin
            r.we = ewe; r.addr = eaddr; r.be = ebe; r.wdata = ewd;
            req_q.push_back(r);
        end
        e.rd = erd; e.err = eerr; e.mis = emis; e.stall = est; e.reqc = erq;
        rsp_q.push_back(e);
        cur_ackdly = ackd;
        cur_rdata  = rdat;
        MemRead    = rd;
        MemWrite   = wr;
        Funct3     = f3;
        Addr       = addr;
        WrData     = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (Stall && n < 100);
        if (n >= 100) begin
            n_cmp++; n_fail++;
            $display("FAIL access_timeout: actual Stall=1 after %0d cycles required release", n);
        end
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check32("rst_mem_req",  32'(mem_req),  32'd0);
        check32("rst_mem_we",   32'(mem_we),   32'd0);
        check32("rst_mem_addr", mem_addr,      32'd0);
        check32("rst_mem_be",   32'(mem_be),   32'd0);
        check32("rst_mem_wdata", mem_wdata,    32'd0);
        check32("rst_RdData",   RdData,        32'd0);
        check32("rst_flags",    {29'd0, Error, Misalign, Stall}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        //      rd wr f3      addr          wdata         ack rdata         req we eaddr         be       ewdata        erd           err mis st rq
        run_vec(1, 0, 3'b010, 32'h0000_0100, 32'h0,        3, 32'hDEADBEEF, 1, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 0, 4, 3);
        run_vec(1, 0, 3'b000, 32'h0000_0103, 32'h0,        1, 32'h80FF0000, 1, 0, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 0, 2, 1);
        run_vec(1, 0, 3'b100, 32'h0000_0103, 32'h0,        1, 32'h80FF0000, 1, 0, 32'h0000_0100, 4'b1000, 32'h0,        32'h00000080, 0, 0, 2, 1);
        run_vec(0, 1, 3'b001, 32'h0000_0202, 32'h1234ABCD, 2, 32'hFFFFFFFF, 1, 1, 32'h0000_0200, 4'b1100, 32'hABCDABCD, 32'h00000080, 0, 0, 3, 2);
        run_vec(1, 0, 3'b001, 32'h0000_0102, 32'h0,        1, 32'h80017FFF, 1, 0, 32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF8001, 0, 0, 2, 1);
        run_vec(1, 0, 3'b101, 32'h0000_0100, 32'h0,        1, 32'h8001F00F, 1, 0, 32'h0000_0100, 4'b0011, 32'h0,        32'h0000F00F, 0, 0, 2, 1);
        run_vec(0, 1, 3'b000, 32'h0000_0101, 32'h000000A5, 1, 32'h0,        1, 1, 32'h0000_0100, 4'b0010, 32'hA5A5A5A5, 32'h0000F00F, 0, 0, 2, 1);
        run_vec(1, 0, 3'b010, 32'h0000_0300, 32'h0,        0, 32'h55555555, 1, 0, 32'h0000_0300, 4'b1111, 32'h0,        32'h00000000, 1, 0, 17, 16);
        run_vec(1, 0, 3'b010, 32'h0000_0304, 32'h0,       16, 32'h12345678, 1, 0, 32'h0000_0304, 4'b1111, 32'h0,        32'h12345678, 0, 0, 17, 16);
        run_vec(1, 1, 3'b010, 32'h0000_0400, 32'hCAFEF00D, 1, 32'h0,        1, 1, 32'h0000_0400, 4'b1111, 32'hCAFEF00D, 32'h12345678, 0, 0, 2, 1);
        run_vec(1, 0, 3'b011, 32'h0000_0208, 32'h0,        2, 32'h89ABCDEF, 1, 0, 32'h0000_0208, 4'b1111, 32'h0,        32'h89ABCDEF, 0, 0, 3, 2);
        run_vec(1, 0, 3'b000, 32'h0000_0101, 32'h0,        1, 32'h00007F00, 1, 0, 32'h0000_0100, 4'b0010, 32'h0,        32'h0000007F, 0, 0, 2, 1);
`ifdef MISALIGN_CHECK_EN
        run_vec(1, 0, 3'b010, 32'h0000_0101, 32'h0,        1, 32'h11223344, 0, 0, 32'h0,         4'b0000, 32'h0,        32'h00000000, 0, 1, 1, 0);
        run_vec(1, 0, 3'b001, 32'h0000_0103, 32'h0,        1, 32'hA5A57F00, 0, 0, 32'h0,         4'b0000, 32'h0,        32'h00000000, 0, 1, 1, 0);
`else
        run_vec(1, 0, 3'b010, 32'h0000_0101, 32'h0,        1, 32'h11223344, 1, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'h11223344, 0, 0, 2, 1);
        run_vec(1, 0, 3'b001, 32'h0000_0103, 32'h0,        1, 32'hA5A57F00, 1, 0, 32'h0000_0100, 4'b1100, 32'h0,        32'hFFFFA5A5, 0, 0, 2, 1);
`endif

        // Reset in the second ACCESS cycle, followed by a late ack
        mon_en     = 1'b0;
        cur_ackdly = 0;
        Funct3     = 3'b010;
        Addr       = 32'h0000_0500;
        MemRead    = 1'b1;
        @(posedge clk); #1;
        check32("rr_req_c1", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        reset   = 1'b1;
        MemRead = 1'b0;
        @(posedge clk); #1;
        reset     = 1'b0;
        force_ack = 1'b1;
        check32("rr_req_after_rst",   32'(mem_req), 32'd0);
        check32("rr_stall_after_rst", 32'(Stall),   32'd0);
        @(posedge clk); #1;
        force_ack = 1'b0;
        check32("rr_req_after_ack",   32'(mem_req), 32'd0);
        check32("rr_flags_after_ack", {29'd0, Error, Misalign, Stall}, 32'd0);
        check32("rr_rddata",          RdData,       32'd0);
        @(posedge clk); #1;
        check32("rr_req_settled",     32'(mem_req), 32'd0);

        check32("req_q_left", 32'(req_q.size()), 32'd0);
        check32("rsp_q_left", 32'(rsp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
